cart_wr_arbiter: RTL and testbench

Shares the cartridge write port between the GB core and one auxiliary write requester (the rumble engine, later save/config writers). Core writes always win and pass through with zero latency. Auxiliary writes are inserted only after the core bus has been quiet for a guard window. They are aborted and retried if the core writes mid-transfer. Sits between the core/rumble engine and the cart pin drivers.

---
 rtl/cart_wr_arbiter.sv | 153 +++++++++++++++
 tb/tb_cart_wr_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cart_wr_arbiter.sv
// Cartridge write-port arbiter: core writes pass through untouched, aux writes are
// slotted in after a core-quiet guard window and retried whenever the core cuts in.
module cart_wr_arbiter #(
  parameter int PULSE_LEN = 8,
  parameter int SETUP_LEN = 2,
  parameter int GUARD_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_wr_n,
  input  logic [15:0] core_addr,
  input  logic [7:0]  core_din,
  input  logic        aux_req,
  input  logic [15:0] aux_addr,
  input  logic [7:0]  aux_din,
  output logic        aux_busy,
  output logic        aux_ack,
  output logic        aux_collision,
  output logic        cart_wr_n,
  output logic [15:0] cart_addr,
  output logic [7:0]  cart_din
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GUARD = 3'd1,
    SETUP = 3'd2,
    PULSE = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam logic [7:0] GUARD_LAST = 8'(GUARD_LEN - 1);
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_LEN - 1);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);

  state_t      state_q, state_d;
  logic [7:0]  guard_cnt_q, guard_cnt_d;
  logic [7:0]  phase_cnt_q, phase_cnt_d;
  logic [15:0] aux_addr_q, aux_addr_d;
  logic [7:0]  aux_din_q, aux_din_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic        coll_q, coll_d;

  // Any core strobe seen in SETUP or PULSE aborts back to GUARD; the latched request survives.
  always_comb begin
    state_d     = state_q;
    guard_cnt_d = guard_cnt_q;
    phase_cnt_d = phase_cnt_q;
    aux_addr_d  = aux_addr_q;
    aux_din_d   = aux_din_q;
    ack_d       = 1'b0;
    coll_d      = 1'b0;
    case (state_q)
      IDLE: begin
        guard_cnt_d = 8'd0;
        phase_cnt_d = 8'd0;
        if (aux_req) begin
          aux_addr_d = aux_addr;
          aux_din_d  = aux_din;
          state_d    = GUARD;
        end
      end
      GUARD: begin
        if (!core_wr_n) begin
          guard_cnt_d = 8'd0;
        end else if (guard_cnt_q == GUARD_LAST) begin
          state_d     = SETUP;
          guard_cnt_d = 8'd0;
          phase_cnt_d = 8'd0;
        end else begin
          guard_cnt_d = guard_cnt_q + 8'd1;
        end
      end
      SETUP: begin
        if (!core_wr_n) begin
          state_d     = GUARD;
          guard_cnt_d = 8'd0;
          phase_cnt_d = 8'd0;
          coll_d      = 1'b1;
        end else if (phase_cnt_q == SETUP_LAST) begin
          state_d     = PULSE;
          phase_cnt_d = 8'd0;
        end else begin
          phase_cnt_d = phase_cnt_q + 8'd1;
        end
      end
      PULSE: begin
        if (!core_wr_n) begin
          state_d     = GUARD;
          guard_cnt_d = 8'd0;
          phase_cnt_d = 8'd0;
          coll_d      = 1'b1;
        end else if (phase_cnt_q == PULSE_LAST) begin
          state_d     = HOLD;
          phase_cnt_d = 8'd0;
        end else begin
          phase_cnt_d = phase_cnt_q + 8'd1;
        end
      end
      HOLD: begin
        state_d     = IDLE;
        phase_cnt_d = 8'd0;
        ack_d       = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        guard_cnt_d = 8'd0;
        phase_cnt_d = 8'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      guard_cnt_q <= 8'd0;
      phase_cnt_q <= 8'd0;
      aux_addr_q  <= 16'd0;
      aux_din_q   <= 8'd0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      coll_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      guard_cnt_q <= guard_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      aux_addr_q  <= aux_addr_d;
      aux_din_q   <= aux_din_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      coll_q      <= coll_d;
    end
  end

  assign aux_busy      = busy_q;
  assign aux_ack       = ack_q;
  assign aux_collision = coll_q;

  // A core strobe always owns the pins, even mid aux transfer, with no added latency.
  always_comb begin
    cart_wr_n = core_wr_n;
    cart_addr = core_addr;
    cart_din  = core_din;
    if (core_wr_n && (state_q == SETUP || state_q == PULSE || state_q == HOLD)) begin
      cart_wr_n = (state_q != PULSE);
      cart_addr = aux_addr_q;
      cart_din  = aux_din_q;
    end
  end

endmodule

// File: tb/tb_cart_wr_arbiter.sv
// Directed bench for cart_wr_arbiter: a timeline model checked every cycle, plus
// hand-computed literal checks for each scenario.
module tb_cart_wr_arbiter;

  localparam int PULSE = 8;
  localparam int SETUP = 2;
  localparam int GUARD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_wr_n = 1'b1;
  logic [15:0] core_addr = 16'h0000;
  logic [7:0]  core_din = 8'h00;
  logic        aux_req = 1'b0;
  logic [15:0] aux_addr = 16'h0000;
  logic [7:0]  aux_din = 8'h00;
  logic        aux_busy, aux_ack, aux_collision, cart_wr_n;
  logic [15:0] cart_addr;
  logic [7:0]  cart_din;

  int vectors = 0;
  int miscompares = 0;

  cart_wr_arbiter #(.PULSE_LEN(PULSE), .SETUP_LEN(SETUP), .GUARD_LEN(GUARD)) dut (
    .clk(clk), .reset(reset),
    .core_wr_n(core_wr_n), .core_addr(core_addr), .core_din(core_din),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_din(aux_din),
    .aux_busy(aux_busy), .aux_ack(aux_ack), .aux_collision(aux_collision),
    .cart_wr_n(cart_wr_n), .cart_addr(cart_addr), .cart_din(cart_din)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic cwn, input logic [15:0] caddr,
                               input logic [7:0] cdin, input logic req,
                               input logic [15:0] aaddr, input logic [7:0] adin);
    @(posedge clk);
    #1;
    reset     = rst;
    core_wr_n = cwn;
    core_addr = caddr;
    core_din  = cdin;
    aux_req   = req;
    aux_addr  = aaddr;
    aux_din   = adin;
    @(negedge clk);
  endtask

  // Model: m_t counts cycles into the aux transfer (-1 while waiting for the guard window).
  bit          m_active = 1'b0;
  int          m_t = -1;
  int          m_quiet = 0;
  logic [15:0] m_addr = 16'h0;
  logic [7:0]  m_din = 8'h0;
  bit          m_ack = 1'b0;
  bit          m_coll = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0; m_t = -1; m_quiet = 0; m_ack = 1'b0; m_coll = 1'b0;
    end else begin
      m_ack = 1'b0;
      m_coll = 1'b0;
      if (!m_active) begin
        if (aux_req) begin
          m_active = 1'b1; m_addr = aux_addr; m_din = aux_din; m_quiet = 0; m_t = -1;
        end
      end else if (m_t < 0) begin
        if (!core_wr_n) m_quiet = 0;
        else m_quiet++;
        if (m_quiet == GUARD) begin
          m_t = 0; m_quiet = 0;
        end
      end else if (m_t < SETUP + PULSE) begin
        if (!core_wr_n) begin
          m_t = -1; m_quiet = 0; m_coll = 1'b1;
        end else begin
          m_t++;
        end
      end else begin
        m_active = 1'b0; m_t = -1; m_ack = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      logic aux_owns;
      logic exp_wr_n;
      aux_owns = core_wr_n && (m_t >= 0);
      exp_wr_n = aux_owns ? !(m_t >= SETUP && m_t < SETUP + PULSE) : core_wr_n;
      checkOutput("model aux_busy", 32'(aux_busy), 32'(m_active));
      checkOutput("model aux_ack", 32'(aux_ack), 32'(m_ack));
      checkOutput("model aux_collision", 32'(aux_collision), 32'(m_coll));
      checkOutput("model cart_wr_n", 32'(cart_wr_n), 32'(exp_wr_n));
      checkOutput("model cart_addr", 32'(cart_addr), 32'(aux_owns ? m_addr : core_addr));
      checkOutput("model cart_din", 32'(cart_din), 32'(aux_owns ? m_din : core_din));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset and idle passthrough
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b1, 16'h1234, 8'h5A, 1'b0, 16'h0, 8'h0);
    checkOutput("reset cart_addr", 32'(cart_addr), 32'h1234);
    applyStimulus(1'b0, 1'b1, 16'h1234, 8'h5A, 1'b0, 16'h0, 8'h0);
    checkOutput("reset aux_busy", 32'(aux_busy), 32'h0);
    checkOutput("reset aux_ack", 32'(aux_ack), 32'h0);
    checkOutput("reset aux_collision", 32'(aux_collision), 32'h0);
    checkOutput("reset cart_wr_n", 32'(cart_wr_n), 32'h1);
    applyStimulus(1'b0, 1'b0, 16'h1234, 8'h5A, 1'b0, 16'h0, 8'h0);
    checkOutput("idle core passthrough wr_n", 32'(cart_wr_n), 32'h0);
    applyStimulus(1'b0, 1'b1, 16'h1234, 8'h5A, 1'b0, 16'h0, 8'h0);

    // Basic aux write, core idle
    for (int c = 0; c <= 17; c++) begin
      applyStimulus(1'b0, 1'b1, 16'h4000, 8'h00, c == 0, 16'h2000, 8'h08);
      case (c)
        1:  checkOutput("t1 busy c1", 32'(aux_busy), 32'h1);
        4:  checkOutput("t1 addr c4", 32'(cart_addr), 32'h4000);
        5:  checkOutput("t1 addr c5", 32'(cart_addr), 32'h2000);
        6:  checkOutput("t1 wr_n c6", 32'(cart_wr_n), 32'h1);
        7:  checkOutput("t1 wr_n c7", 32'(cart_wr_n), 32'h0);
        14: checkOutput("t1 wr_n c14", 32'(cart_wr_n), 32'h0);
        15: begin
          checkOutput("t1 wr_n c15", 32'(cart_wr_n), 32'h1);
          checkOutput("t1 busy c15", 32'(aux_busy), 32'h1);
        end
        16: begin
          checkOutput("t1 ack c16", 32'(aux_ack), 32'h1);
          checkOutput("t1 busy c16", 32'(aux_busy), 32'h0);
        end
        default: ;
      endcase
    end

    // Core strobes during GUARD restart the window
    for (int c = 0; c <= 21; c++) begin
      applyStimulus(1'b0, !(c == 2 || c == 4), 16'h4000, 8'h55, c == 0, 16'h2100, 8'h09);
      case (c)
        2:  checkOutput("t2 core wr_n c2", 32'(cart_wr_n), 32'h0);
        8:  checkOutput("t2 addr c8", 32'(cart_addr), 32'h4000);
        9:  checkOutput("t2 addr c9", 32'(cart_addr), 32'h2100);
        19: checkOutput("t2 ack c19", 32'(aux_ack), 32'h0);
        20: checkOutput("t2 ack c20", 32'(aux_ack), 32'h1);
        default: ;
      endcase
    end

    // Core write mid-PULSE aborts and retries
    for (int c = 0; c <= 26; c++) begin
      applyStimulus(1'b0, c != 9, 16'h4000, 8'hAA, c == 0, 16'h2000, 8'h08);
      case (c)
        9: begin
          checkOutput("t3 wr_n c9", 32'(cart_wr_n), 32'h0);
          checkOutput("t3 addr c9", 32'(cart_addr), 32'h4000);
          checkOutput("t3 din c9", 32'(cart_din), 32'hAA);
        end
        10: checkOutput("t3 collision c10", 32'(aux_collision), 32'h1);
        16: checkOutput("t3 retry wr_n c16", 32'(cart_wr_n), 32'h0);
        23: checkOutput("t3 retry wr_n c23", 32'(cart_wr_n), 32'h0);
        24: checkOutput("t3 hold wr_n c24", 32'(cart_wr_n), 32'h1);
        25: checkOutput("t3 ack c25", 32'(aux_ack), 32'h1);
        default: ;
      endcase
    end

    // Core write during HOLD: no abort
    for (int c = 0; c <= 17; c++) begin
      applyStimulus(1'b0, c != 15, 16'h4000, 8'hCC, c == 0, 16'h2000, 8'h08);
      case (c)
        15: begin
          checkOutput("t4 wr_n c15", 32'(cart_wr_n), 32'h0);
          checkOutput("t4 din c15", 32'(cart_din), 32'hCC);
        end
        16: begin
          checkOutput("t4 collision c16", 32'(aux_collision), 32'h0);
          checkOutput("t4 ack c16", 32'(aux_ack), 32'h1);
        end
        default: ;
      endcase
    end

    // Request while busy is ignored; request in the ack cycle is accepted
    for (int c = 0; c <= 33; c++) begin
      logic [15:0] a;
      logic [7:0]  d;
      a = (c == 3) ? 16'h3300 : (c >= 16) ? 16'h2400 : 16'h2200;
      d = (c == 3) ? 8'h22 : (c >= 16) ? 8'h33 : 8'h11;
      applyStimulus(1'b0, 1'b1, 16'h4000, 8'h00, (c == 0 || c == 3 || c == 16), a, d);
      case (c)
        7: begin
          checkOutput("t5 addr c7", 32'(cart_addr), 32'h2200);
          checkOutput("t5 din c7", 32'(cart_din), 32'h11);
        end
        16: checkOutput("t5 ack c16", 32'(aux_ack), 32'h1);
        17: checkOutput("t5 busy c17", 32'(aux_busy), 32'h1);
        21: begin
          checkOutput("t5 addr c21", 32'(cart_addr), 32'h2400);
          checkOutput("t5 din c21", 32'(cart_din), 32'h33);
        end
        32: checkOutput("t5 ack c32", 32'(aux_ack), 32'h1);
        default: ;
      endcase
    end

    // Reset mid-PULSE drops the transfer
    for (int c = 0; c <= 20; c++) begin
      applyStimulus(c == 8, 1'b1, 16'h4000, 8'h00, c == 0, 16'h2000, 8'h08);
      case (c)
        7: checkOutput("t6 wr_n c7", 32'(cart_wr_n), 32'h0);
        9: begin
          checkOutput("t6 wr_n c9", 32'(cart_wr_n), 32'h1);
          checkOutput("t6 busy c9", 32'(aux_busy), 32'h0);
        end
        16: checkOutput("t6 ack c16", 32'(aux_ack), 32'h0);
        20: checkOutput("t6 busy c20", 32'(aux_busy), 32'h0);
        default: ;
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
